// File: rtl/modport_converse_pkg.sv
// Shared types and helpers for the converse-link transmitter.
package modport_converse_pkg;

  // Transmitter FSM: IDLE accepts a word, SEND shifts it out one bit per handshake.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Counter width for counting up to n-1; never narrower than one bit so a
  // disabled or trivial counter still has a legal declaration.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/modport_converse_shifter.sv
// Loadable shift register presenting the current bit to send on the link.
module modport_converse_shifter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] data,
  output logic             cur_bit
);

  logic [WIDTH-1:0] sr;

  // Load a fresh word or advance by one bit toward the output end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= data;
    end else if (shift_en) begin
      if (MSB_FIRST) begin
        sr <= {sr[WIDTH-2:0], 1'b0};
      end else begin
        sr <= {1'b0, sr[WIDTH-1:1]};
      end
    end
  end

  // The output end is the MSB when sending MSB first, else the LSB.
  assign cur_bit = MSB_FIRST ? sr[WIDTH-1] : sr[0];

endmodule

// File: rtl/modport_converse_tx.sv
// Word-to-bit serializer driving the slave end of the converse link.
//
// Handshakes:
//   word port : a word transfers on a rising edge where i_valid && o_ready;
//               o_ready is high only in IDLE and does not depend on i_valid.
//   link      : a bit transfers on a rising edge where o_a && i_c; o_a and
//               o_b are registered and o_b is held while o_a=1 and i_c=0.
//               i_d in SEND aborts the word and takes priority over i_c.
module modport_converse_tx
  import modport_converse_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_a,
  output logic             o_b,
  input  logic             i_c,
  input  logic             i_d,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_abort,
  output logic             o_timeout,
  output state_t           o_state
);

  localparam int BW = cnt_width(WIDTH);
  localparam int SW = cnt_width(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(WIDTH - 1);
  localparam logic [SW-1:0] STALL_LIMIT = SW'(TIMEOUT);

  state_t          state;
  logic [BW-1:0]   bit_cnt;
  logic [SW-1:0]   stall_cnt;
  logic [SW-1:0]   stall_inc;
  logic            timeout_hit;
  logic            load;
  logic            shift_en;
  logic            ready_q;
  logic            a_q;
  logic            busy_q;
  logic            done_q;
  logic            abort_q;
  logic            timeout_q;

  // Word load in IDLE; bit advance on a completed, non-aborted handshake.
  assign load     = (state == IDLE) && i_valid;
  assign shift_en = (state == SEND) && i_c && !i_d;

  // Saturating stall increment and the self-abort condition it feeds.
  always_comb begin
    stall_inc   = (stall_cnt == '1) ? stall_cnt : stall_cnt + SW'(1);
    timeout_hit = 1'b0;
    if (TIMEOUT > 0) begin
      timeout_hit = (stall_inc == STALL_LIMIT);
    end
  end

  // Transmit FSM with bit/stall counters and registered status pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      stall_cnt <= '0;
      ready_q   <= 1'b1;
      a_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            state     <= SEND;
            bit_cnt   <= '0;
            stall_cnt <= '0;
            ready_q   <= 1'b0;
            a_q       <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        SEND: begin
          if (i_d) begin
            // Far-end abort: the bit in flight is discarded.
            state   <= IDLE;
            ready_q <= 1'b1;
            a_q     <= 1'b0;
            busy_q  <= 1'b0;
            abort_q <= 1'b1;
          end else if (i_c) begin
            stall_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              state   <= IDLE;
              ready_q <= 1'b1;
              a_q     <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else if (timeout_hit) begin
            state     <= IDLE;
            stall_cnt <= stall_inc;
            ready_q   <= 1'b1;
            a_q       <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            stall_cnt <= stall_inc;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  modport_converse_shifter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (load),
    .shift_en (shift_en),
    .data     (i_data),
    .cur_bit  (o_b)
  );

  assign o_ready   = ready_q;
  assign o_a       = a_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_abort   = abort_q;
  assign o_timeout = timeout_q;
  assign o_state   = state;

endmodule

// File: tb/tb_modport_converse_tx.sv
// Bench for modport_converse_tx: three instances (MSB first, LSB first,
// MSB first with TIMEOUT=4), each with its own handshake inputs.
module tb_modport_converse_tx;
  import modport_converse_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic [2:0] valid = '0;
  logic [2:0] c = '0;
  logic [2:0] d = '0;
  logic [2:0] ready, a, b, busy, done, abort, tmo;
  state_t     st [3];

  int total = 0;
  int bad   = 0;
  logic [0:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, want test done");
    $fatal(1, "watchdog");
  end

  modport_converse_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .TIMEOUT(0)) u_msb (
    .i_clk(clk), .i_rst(rst), .i_valid(valid[0]), .o_ready(ready[0]), .i_data(data),
    .o_a(a[0]), .o_b(b[0]), .i_c(c[0]), .i_d(d[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_abort(abort[0]), .o_timeout(tmo[0]), .o_state(st[0]));

  modport_converse_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .TIMEOUT(0)) u_lsb (
    .i_clk(clk), .i_rst(rst), .i_valid(valid[1]), .o_ready(ready[1]), .i_data(data),
    .o_a(a[1]), .o_b(b[1]), .i_c(c[1]), .i_d(d[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_abort(abort[1]), .o_timeout(tmo[1]), .o_state(st[1]));

  modport_converse_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .TIMEOUT(4)) u_tmo (
    .i_clk(clk), .i_rst(rst), .i_valid(valid[2]), .o_ready(ready[2]), .i_data(data),
    .o_a(a[2]), .o_b(b[2]), .i_c(c[2]), .i_d(d[2]), .o_busy(busy[2]), .o_done(done[2]),
    .o_abort(abort[2]), .o_timeout(tmo[2]), .o_state(st[2]));

  // ---------------- driver / scoreboard tasks ----------------

  // Reset values on every instance while reset is held.
  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({ready[k], a[k], b[k], busy[k], done[k], abort[k], tmo[k]} !== 7'b1000000) begin
        bad++;
        $display("FAIL reset_outs[%0d]: got %b want 1000000", k,
                 {ready[k], a[k], b[k], busy[k], done[k], abort[k], tmo[k]});
      end
    end
  endtask

  // Offer w to instance k, then run the link; rnd randomizes i_c,
  // abort_at >= 0 raises i_d together with i_c once that many bits are sent.
  task automatic send_word(input int k, input logic [7:0] w, input bit rnd, input int abort_at);
    int         n;
    int         cyc;
    logic       prev_b;
    bit         stalled;
    logic [7:0] got;
    logic [0:0] exp_bit;
    @(negedge clk);
    data = w; valid[k] = 1'b1; c[k] = 1'b0; d[k] = 1'b0;
    total++;
    if (ready[k] !== 1'b1) begin
      bad++; $display("FAIL offer_ready[%0d]: got %b want 1", k, ready[k]);
    end
    for (int i = 0; i < 8; i++) exp_q.push_back((k == 1) ? w[i] : w[7-i]);
    @(negedge clk);
    valid[k] = 1'b0;
    n = 0; cyc = 0; stalled = 1'b0; got = '0; prev_b = 1'b0;
    forever begin
      c[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (n == abort_at) begin c[k] = 1'b1; d[k] = 1'b1; end
      total++;
      if (a[k] !== 1'b1 || busy[k] !== 1'b1 || ready[k] !== 1'b0 || st[k] !== SEND) begin
        bad++; $display("FAIL send_state[%0d]: got a=%b busy=%b ready=%b want 1 1 0", k, a[k], busy[k], ready[k]);
      end
      if (stalled) begin
        total++;
        if (b[k] !== prev_b) begin
          bad++; $display("FAIL b_stable[%0d]: got %b want %b", k, b[k], prev_b);
        end
      end
      if (c[k] && !d[k]) begin
        exp_bit = exp_q.pop_front();
        total++;
        if (b[k] !== exp_bit) begin
          bad++; $display("FAIL bit%0d[%0d]: got %b want %b", n, k, b[k], exp_bit);
        end
        got = (k == 1) ? {b[k], got[7:1]} : {got[6:0], b[k]};
        n++;
      end
      prev_b = b[k];
      stalled = !c[k];
      @(negedge clk);
      cyc++;
      if (d[k]) begin
        d[k] = 1'b0; c[k] = 1'b0;
        total++;
        if ({abort[k], done[k], a[k], ready[k], busy[k]} !== 5'b10010) begin
          bad++; $display("FAIL abort_end[%0d]: got %b want 10010", k,
                          {abort[k], done[k], a[k], ready[k], busy[k]});
        end
        exp_q.delete();
        return;
      end
      if (n == 8) begin
        c[k] = 1'b0;
        total++;
        if ({done[k], ready[k], a[k], busy[k]} !== 4'b1100) begin
          bad++; $display("FAIL done_end[%0d]: got %b want 1100", k, {done[k], ready[k], a[k], busy[k]});
        end
        total++;
        if (got !== w) begin
          bad++; $display("FAIL rx_word[%0d]: got %h want %h", k, got, w);
        end
        @(negedge clk);
        total++;
        if (done[k] !== 1'b0) begin
          bad++; $display("FAIL done_once[%0d]: got %b want 0", k, done[k]);
        end
        return;
      end
      total++;
      if (done[k] !== 1'b0 || abort[k] !== 1'b0) begin
        bad++; $display("FAIL early_pulse[%0d]: got done=%b abort=%b want 0 0", k, done[k], abort[k]);
      end
      if (cyc > 200) begin
        total++; bad++;
        $display("FAIL word_budget[%0d]: got %0d bits want 8", k, n);
        exp_q.delete(); c[k] = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_msb_first();
    send_word(0, 8'hA5, 1'b0, -1);
  endtask

  task automatic test_lsb_first();
    send_word(1, 8'hA5, 1'b0, -1);
  endtask

  task automatic test_random_stall();
    send_word(0, 8'h3C, 1'b1, -1);
    send_word(1, 8'h3C, 1'b1, -1);
  endtask

  task automatic test_abort();
    send_word(0, 8'hA5, 1'b0, 3);
    send_word(0, 8'h3C, 1'b0, -1);
  endtask

  task automatic test_idle_abort_ignored();
    @(negedge clk);
    d[0] = 1'b1;
    @(negedge clk);
    d[0] = 1'b0;
    total++;
    if ({abort[0], ready[0], a[0]} !== 3'b010) begin
      bad++; $display("FAIL idle_d: got %b want 010", {abort[0], ready[0], a[0]});
    end
  endtask

  // TIMEOUT=4 with i_c held 0; with_abort raises i_d on the expiring cycle.
  task automatic test_timeout(input bit with_abort);
    @(negedge clk);
    data = 8'hF0; valid[2] = 1'b1; c[2] = 1'b0; d[2] = 1'b0;
    @(negedge clk);
    valid[2] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (a[2] !== 1'b1 || tmo[2] !== 1'b0) begin
        bad++; $display("FAIL tmo_wait%0d: got a=%b tmo=%b want 1 0", i, a[2], tmo[2]);
      end
      if (i == 4) d[2] = with_abort;
      @(negedge clk);
    end
    d[2] = 1'b0;
    total++;
    if ({tmo[2], abort[2], a[2], ready[2]} !== (with_abort ? 4'b0101 : 4'b1001)) begin
      bad++; $display("FAIL tmo_fire: got %b want %b", {tmo[2], abort[2], a[2], ready[2]},
                      with_abort ? 4'b0101 : 4'b1001);
    end
    @(negedge clk);
    total++;
    if (tmo[2] !== 1'b0 || abort[2] !== 1'b0) begin
      bad++; $display("FAIL tmo_once: got tmo=%b abort=%b want 0 0", tmo[2], abort[2]);
    end
  endtask

  task automatic test_reset_mid_word();
    @(negedge clk);
    data = 8'h5A; valid[0] = 1'b1; c[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({ready[0], a[0], b[0], busy[0], done[0], abort[0], tmo[0]} !== 7'b1000000 || st[0] !== IDLE) begin
      bad++; $display("FAIL async_reset: got %b want 1000000",
                      {ready[0], a[0], b[0], busy[0], done[0], abort[0], tmo[0]});
    end
    @(negedge clk);
    rst = 1'b0; c[0] = 1'b0;
    send_word(0, 8'hC3, 1'b0, -1);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_msb_first();
    test_lsb_first();
    test_random_stall();
    test_abort();
    test_idle_abort_ignored();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_word();
    send_word(0, 8'(($urandom_range(0, 255))), 1'b1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
